// File: rtl/uart_calc_core.sv
// uart_calc_core: parses "A op B" (= or CR terminated) from rx bytes and replies with the decimal result + CR LF.
// Define UART_CALC_DIV_EN to accept '/' and build the 9-cycle restoring divider used in ST_CALC.
module uart_calc_core #(
    parameter int TX_GAP = 176
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy
);
    localparam logic [7:0] CH_CR = 8'h0d, CH_LF = 8'h0a, CH_SP = 8'h20, CH_EQ = 8'h3d, CH_E = 8'h45;
    localparam logic [7:0] OP_ADD = 8'h2b, OP_SUB = 8'h2d, OP_MUL = 8'h2a, OP_DIV = 8'h2f;

    typedef enum logic [2:0] {ST_A, ST_B, ST_SKIP, ST_CALC, ST_CONV, ST_SEND} state_t;

    state_t      state, state_nx;
    logic [7:0]  a, a_nx, b, b_nx, op, op_nx;
    logic        err, err_nx, seen, seen_nx, lead, lead_nx;
    logic [15:0] val, val_nx, gap, gap_nx;
    logic [2:0]  dig, dig_nx;
    logic [3:0]  q, q_nx, len, len_nx, idx, idx_nx;
    logic [7:0]  obuf [8];
    logic [7:0]  obuf_nx [8];
    logic [7:0]  tx_data_nx;
    logic        tx_valid_nx;
    logic        is_digit, is_term, is_op, to_skip, to_err, to_conv;
    logic [11:0] acc;
    logic [16:0] r;
    logic [15:0] dec;
`ifdef UART_CALC_DIV_EN
    logic [7:0]  rem, rem_nx, quo, quo_nx;
    logic [3:0]  dcnt, dcnt_nx;
    logic [8:0]  shl;
    logic        fits;
`endif

    assign busy     = (state == ST_CALC) || (state == ST_CONV) || (state == ST_SEND);
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term  = (rx_data == CH_EQ) || (rx_data == CH_CR);
`ifdef UART_CALC_DIV_EN
    assign is_op    = (rx_data == OP_ADD) || (rx_data == OP_SUB) || (rx_data == OP_MUL) || (rx_data == OP_DIV);
    assign shl      = {rem, quo[7]};
    assign fits     = shl >= {1'b0, b};
`else
    assign is_op    = (rx_data == OP_ADD) || (rx_data == OP_SUB) || (rx_data == OP_MUL);
`endif
    assign acc = {4'd0, (state == ST_B) ? b : a} * 12'd10 + {8'd0, rx_data[3:0]};
    assign dec = dig == 3'd0 ? 16'd10000 : dig == 3'd1 ? 16'd1000 : dig == 3'd2 ? 16'd100 :
                 dig == 3'd3 ? 16'd10 : 16'd1;

    // Two's-complement 17-bit result; for '/' this is the quotient after the current divider step.
    always_comb begin
        r = op == OP_ADD ? {9'd0, a} + {9'd0, b} :
            op == OP_SUB ? {9'd0, a} - {9'd0, b} : {9'd0, a} * {9'd0, b};
`ifdef UART_CALC_DIV_EN
        if (op == OP_DIV) r = {9'd0, quo[6:0], fits};
`endif
    end

    always_comb begin
        state_nx    = state;
        a_nx        = a;
        b_nx        = b;
        op_nx       = op;
        err_nx      = err;
        seen_nx     = seen;
        lead_nx     = lead;
        val_nx      = val;
        gap_nx      = gap;
        dig_nx      = dig;
        q_nx        = q;
        len_nx      = len;
        idx_nx      = idx;
        obuf_nx     = obuf;
        tx_data_nx  = tx_data;
        tx_valid_nx = 1'b0;
        to_skip     = 1'b0;
        to_err      = 1'b0;
        to_conv     = 1'b0;
`ifdef UART_CALC_DIV_EN
        rem_nx      = rem;
        quo_nx      = quo;
        dcnt_nx     = dcnt;
`endif
        case (state)
            ST_A, ST_B: begin
                if (rx_valid && rx_data != CH_SP) begin
                    if (is_digit) begin
                        to_skip = acc > 12'd255;
                        seen_nx = 1'b1;
                        if (state == ST_A) a_nx = acc[7:0];
                        else b_nx = acc[7:0];
                    end else if (state == ST_A && is_op && seen) begin
                        op_nx    = rx_data;
                        seen_nx  = 1'b0;
                        state_nx = ST_B;
                    end else if (is_term) begin
                        state_nx = ST_CALC;
                        to_err   = (state == ST_A) || !seen;
                    end else begin
                        to_skip = 1'b1;
                    end
                end
            end
            ST_SKIP: to_err = rx_valid && is_term;
            ST_CALC: begin
`ifdef UART_CALC_DIV_EN
                if (op == OP_DIV) begin
                    if (b == 8'd0) begin
                        to_err = 1'b1;
                    end else if (dcnt == 4'd0) begin
                        rem_nx  = 8'd0;
                        quo_nx  = a;
                        dcnt_nx = 4'd1;
                    end else begin
                        rem_nx  = fits ? 8'(shl - {1'b0, b}) : shl[7:0];
                        quo_nx  = {quo[6:0], fits};
                        dcnt_nx = dcnt + 4'd1;
                        to_conv = dcnt == 4'd8;
                    end
                end else
`endif
                to_conv = 1'b1;
            end
            ST_CONV: begin
                if (dig == 3'd5) begin
                    obuf_nx[len[2:0]]        = CH_CR;
                    obuf_nx[len[2:0] + 3'd1] = CH_LF;
                    len_nx   = len + 4'd2;
                    idx_nx   = 4'd0;
                    gap_nx   = 16'd0;
                    state_nx = ST_SEND;
                end else if (val >= dec) begin
                    val_nx = val - dec;
                    q_nx   = q + 4'd1;
                end else begin
                    // the units decade always emits so that a zero result prints "0"
                    if (q != 4'd0 || lead || dig == 3'd4) begin
                        obuf_nx[len[2:0]] = {4'h3, q};
                        len_nx  = len + 4'd1;
                        lead_nx = 1'b1;
                    end
                    dig_nx = dig + 3'd1;
                    q_nx   = 4'd0;
                end
            end
            ST_SEND: begin
                if (gap != 16'd0) begin
                    gap_nx = gap - 16'd1;
                end else if (idx == len) begin
                    state_nx = ST_A;
                    a_nx     = 8'd0;
                    b_nx     = 8'd0;
                    err_nx   = 1'b0;
                    seen_nx  = 1'b0;
                end else begin
                    tx_valid_nx = 1'b1;
                    tx_data_nx  = obuf[idx[2:0]];
                    idx_nx      = idx + 4'd1;
                    gap_nx      = 16'(TX_GAP - 1);
                end
            end
            default: state_nx = ST_A;
        endcase
        if (to_conv) begin
            val_nx     = 16'(r[16] ? -r : r);
            obuf_nx[0] = OP_SUB;
            len_nx     = {3'd0, r[16]};
            dig_nx     = 3'd0;
            q_nx       = 4'd0;
            lead_nx    = 1'b0;
            state_nx   = ST_CONV;
        end
        if (to_skip) begin
            err_nx   = 1'b1;
            state_nx = ST_SKIP;
        end
        if (to_err) begin
            err_nx     = 1'b1;
            obuf_nx[0] = CH_E;
            obuf_nx[1] = CH_CR;
            obuf_nx[2] = CH_LF;
            len_nx     = 4'd3;
            idx_nx     = 4'd0;
            gap_nx     = 16'd0;
            state_nx   = ST_SEND;
        end
`ifdef UART_CALC_DIV_EN
        if (to_conv || to_err) dcnt_nx = 4'd0;
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_A;
            a        <= 8'd0;
            b        <= 8'd0;
            op       <= 8'd0;
            err      <= 1'b0;
            seen     <= 1'b0;
            lead     <= 1'b0;
            val      <= 16'd0;
            gap      <= 16'd0;
            dig      <= 3'd0;
            q        <= 4'd0;
            len      <= 4'd0;
            idx      <= 4'd0;
            obuf     <= '{default: 8'h00};
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
`ifdef UART_CALC_DIV_EN
            rem      <= 8'd0;
            quo      <= 8'd0;
            dcnt     <= 4'd0;
`endif
        end else begin
            state    <= state_nx;
            a        <= a_nx;
            b        <= b_nx;
            op       <= op_nx;
            err      <= err_nx;
            seen     <= seen_nx;
            lead     <= lead_nx;
            val      <= val_nx;
            gap      <= gap_nx;
            dig      <= dig_nx;
            q        <= q_nx;
            len      <= len_nx;
            idx      <= idx_nx;
            obuf     <= obuf_nx;
            tx_data  <= tx_data_nx;
            tx_valid <= tx_valid_nx;
`ifdef UART_CALC_DIV_EN
            rem      <= rem_nx;
            quo      <= quo_nx;
            dcnt     <= dcnt_nx;
`endif
        end
    end
endmodule

// File: tb/tb_uart_calc_core.sv
// tb_uart_calc_core: directed and random expressions checked against a string-level reference model.
module tb_uart_calc_core;
    localparam int TX_GAP = 176;
`ifdef UART_CALC_DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    logic       clk = 1'b0, n_rst = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid, busy;
    int         n_vec = 0, n_err = 0, cyc = 0, tnum = 0;
    logic [7:0] txq[$];
    int         tcyc[$];
    bit         tbusy[$];

    uart_calc_core #(.TX_GAP(TX_GAP)) dut (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (n_rst && tx_valid) begin
            txq.push_back(tx_data);
            tcyc.push_back(cyc);
            tbusy.push_back(busy);
        end
    end

    task automatic chk(string tag, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string t(string n);
        return $sformatf("%s#%0d", n, tnum);
    endfunction

    // Reply expected for one expression: parse the text, do the arithmetic, format with %d.
    function automatic string model(string s);
        int  v[2];
        int  n[2];
        int  ph = 0;
        int  r = 0;
        bit  bad = 1'b0;
        byte op = 0;
        byte c;
        string e_resp = $sformatf("E%c%c", 8'd13, 8'd10);
        v[0] = 0; v[1] = 0; n[0] = 0; n[1] = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == " ") continue;
            if (c == "=" || c == 8'd13) begin
                if (bad || ph == 0 || n[1] == 0) return e_resp;
                if (op == "+") r = v[0] + v[1];
                else if (op == "-") r = v[0] - v[1];
                else if (op == "*") r = v[0] * v[1];
                else if (v[1] == 0) return e_resp;
                else r = v[0] / v[1];
                return $sformatf("%0d%c%c", r, 8'd13, 8'd10);
            end
            if (bad) continue;
            if (c >= "0" && c <= "9") begin
                v[ph] = v[ph] * 10 + (c - "0");
                n[ph]++;
                bad = v[ph] > 255;
            end else if (ph == 0 && n[0] > 0 && (c == "+" || c == "-" || c == "*" || (DIV && c == "/"))) begin
                op = c;
                ph = 1;
            end else begin
                bad = 1'b1;
            end
        end
        return "";
    endfunction

    task automatic send(string s);
        for (int i = 0; i < s.len(); i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 rx_data = s[i];
            rx_valid = 1'b1;
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic run(string s, bit junk);
        string e;
        e = model(s);
        tnum++;
        txq.delete();
        tcyc.delete();
        tbusy.delete();
        send(s);
        chk(t("busy_on"), busy, 1);
        if (junk) begin
            for (int i = 0; i < 3000 && txq.size() == 0; i++) @(negedge clk);
            send("77+1=");
        end
        for (int i = 0; i < 4000 && txq.size() < e.len(); i++) @(negedge clk);
        chk(t("nbytes"), txq.size(), e.len());
        for (int i = 0; i < e.len() && i < txq.size(); i++) begin
            chk(t("byte"), txq[i], e[i]);
            chk(t("busy_tx"), tbusy[i], 1);
            if (i > 0) chk(t("gap"), tcyc[i] - tcyc[i-1], TX_GAP);
        end
        for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
        if (txq.size() > 0) chk(t("tail"), cyc - tcyc[txq.size()-1], TX_GAP);
        chk(t("extra"), txq.size(), e.len());
    endtask

    task automatic rand_expr(output string s);
        string ops = "+-*/";
        int    a, b;
        byte   op;
        string sp;
        a  = $urandom_range(0, 15) == 0 ? 256 + $urandom_range(0, 40) : $urandom_range(0, 255);
        b  = $urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom_range(0, 255);
        op = $urandom_range(0, 9) == 0 ? 8'h78 : ops[$urandom_range(0, 3)];
        sp = $urandom_range(0, 1) ? " " : "";
        s  = $sformatf("%0d%s%c%s%0d%c", a, sp, op, sp, b, $urandom_range(0, 1) ? 8'h3d : 8'h0d);
    endtask

    initial begin
        string s;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        run("12+34=", 0);
        run($sformatf("5 - 20%c", 8'd13), 0);
        run("255*255=", 0);
        run("0+0=", 0);
        run("256+1=", 0);
        run("7-7=", 0);
        run("1x2=", 0);
        run("7-7=", 0);
        run("+3=", 0);
        run("7-7=", 0);
        run("5=", 0);
        run("100/7=", 0);
        run("9/0=", 0);
        run("8*9=", 1);
        run("1+1=", 0);
        // abort mid-reply between the 2nd and 3rd byte
        tnum++;
        txq.delete();
        tcyc.delete();
        tbusy.delete();
        send("12+34=");
        for (int i = 0; i < 3000 && txq.size() < 2; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk(t("abort_tx_valid"), tx_valid, 0);
        chk(t("abort_tx_data"), tx_data, 0);
        chk(t("abort_busy"), busy, 0);
        repeat (5) @(negedge clk);
        n_rst = 1'b1;
        repeat (400) @(negedge clk);
        chk(t("no_resume"), txq.size(), 2);
        run("3*4=", 0);
        for (int k = 0; k < 20; k++) begin
            rand_expr(s);
            run(s, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_calc_core.md
# uart_calc_core

Expression-evaluating command engine sitting directly downstream of the `uart` block's receiver and upstream of its transmitter. It consumes received ASCII bytes (`rx_data`/`rx_valid`), parses a single infix expression of the form `A op B` terminated by `=` or CR, and computes the result. It returns the decimal ASCII result followed by CR LF on `tx_data`/`tx_valid`, pacing bytes so the transmitter is never overrun.

## Interface
- `TX_GAP`, 176: cycles between successive `tx_valid` pulses; must be at least the UART frame length in clocks (10 bits × 16 clk/bit + margin).
- `clk`  in  1  system clock; all logic on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte from `uart`; valid only while `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `tx_data`  out  8  byte to transmit; stable from its `tx_valid` pulse until the next pulse.
- `tx_valid`  out  1  one-cycle transmit strobe to `uart`.
- `busy`  out  1  high in CALC, CONV and SEND; received bytes are dropped while high.

## Operation
- FSM states: `ST_A`, `ST_B`, `ST_SKIP`, `ST_CALC`, `ST_CONV`, `ST_SEND`.
- Space (0x20) is ignored in `ST_A`, `ST_B` and `ST_SKIP`.
- `ST_A`:
  - A digit `0`–`9` updates A ← A×10 + d.
  - An operator (`+` `-` `*`, plus `/` if enabled) with ≥1 digit seen latches op and moves to `ST_B`.
- `ST_B`:
  - Digits accumulate B the same way.
  - `=` (0x3D) or CR (0x0D) with ≥1 digit seen moves to `ST_CALC`.
- Operands are unsigned 0–255.
- Error causes:
  - an accumulated value >255;
  - any other character;
  - an operator or terminator with no digits;
  - divide by zero.
- An error sets `err` and moves to `ST_SKIP`.
- `ST_SKIP` discards bytes until `=` or CR, then goes to `ST_SEND` with the buffer set to `E`,CR,LF.
- A terminator arriving in `ST_A` is also an error, handled immediately with no skip.
- `ST_CALC`:
  - Result R is 17-bit signed.
  - `+` gives A+B; `-` gives A−B (may be negative); `*` gives A×B (max 65025).
  - All of these complete in 1 cycle.
- `ST_CONV`:
  - If R<0, emit `-` and continue with |R|.
  - Divide by 10000, 1000, 100, 10, 1 using repeated subtraction, 1 cycle per subtraction.
  - Leading zeros are suppressed, but a value of 0 emits `0`.
  - CR, LF are appended.
  - Output buffer is up to 8 bytes.
- `ST_SEND`:
  - Emits buffer bytes in order.
  - After the last byte's gap expires, clears A, B and flags and returns to `ST_A`.
- Reset values:
  - state `ST_A`, A=B=0, `err`=0;
  - `tx_data`=8'h00, `tx_valid`=0, `busy`=0.

## Timing
- `rx_valid` is sampled every cycle; a byte is absorbed in the same edge; no backpressure.
- Terminator on cycle t: `ST_CALC` at t+1, `ST_CONV` at t+2.
- CONV takes at most 5×10 cycles plus 1 finalize cycle.
- First `tx_valid` occurs 1 cycle after entering `ST_SEND`.
- Each subsequent `tx_valid` occurs exactly `TX_GAP` cycles after the previous one.
- `busy` deasserts `TX_GAP` cycles after the last pulse. A byte arriving on that same cycle is accepted.
- `rx_valid` while `busy`=1 is dropped with no state change.
- Reset mid-operation aborts immediately: `tx_valid` is 0 from the reset assertion on, and no partial frame is resumed.

## Configuration
- `UART_CALC_DIV_EN` defined:
  - `/` is a legal operator giving the integer quotient A/B.
  - A 9-cycle restoring divider runs in `ST_CALC`.
  - B=0 yields `E`,CR,LF.
- Undefined:
  - `/` is an invalid character and produces the error response.
  - No divider logic is synthesized.
  - `ST_CALC` is always 1 cycle.

## Test plan
- "12+34=" → tx bytes 0x34,0x36,0x0D,0x0A; pulses exactly `TX_GAP` apart; `busy` high throughout.
- "5 - 20" CR → "-15" CR LF (0x2D,0x31,0x35,0x0D,0x0A).
- "255*255=" → "65025" CR LF. "0+0=" → "0" CR LF.
- Each of "256+1=", "1x2=" and "+3=" → "E" CR LF, and the next "7-7=" → "0" CR LF.
- With `UART_CALC_DIV_EN`: "100/7=" → "14" CR LF and "9/0=" → "E" CR LF. Without the macro: "100/7=" → "E" CR LF.
- Bytes sent while `busy` are dropped. Asserting `n_rst` low between the 2nd and 3rd tx byte gives `tx_valid`=0 and `tx_data`=0x00; after release, "3*4=" → "12" CR LF.
